// File: rtl/gcd_engine.sv
// Subtractive GCD engine: one compare or one subtract per clock, with abort and a
// held result that waits for ack.
module gcd_engine #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ITER_W = WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  x_in,
   input  logic [WIDTH-1:0]  y_in,
   input  logic              abort,
   input  logic              ack,
   output logic              ready,
   output logic              done,
   output logic [WIDTH-1:0]  gcd_out,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              err
);

   typedef enum logic [2:0] {StIdle, StCmp, StSubX, StSubY, StDone} state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  x_q, y_q, gcd_q;
   logic [ITER_W-1:0] iter_q, iter_inc;
   logic              err_q;

   assign iter_inc = (&iter_q) ? iter_q : iter_q + ITER_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = (x_in != '0 && y_in != '0) ? StCmp : StDone;
            end
         end
         StCmp: begin
            if (abort) begin
               state_d = StIdle;
            end else if (x_q > y_q) begin
               state_d = StSubX;
            end else if (x_q < y_q) begin
               state_d = StSubY;
            end else begin
               state_d = StDone;
            end
         end
         StSubX, StSubY: state_d = abort ? StIdle : StCmp;
         StDone: begin
            if (ack) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      ready = (state_q == StIdle);
      done  = (state_q == StDone);
   end

   // An aborting edge leaves every working register untouched.
   always_ff @(posedge clk) begin
      if (!rst) begin
         x_q    <= '0;
         y_q    <= '0;
         gcd_q  <= '0;
         iter_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  x_q    <= x_in;
                  y_q    <= y_in;
                  iter_q <= '0;
                  err_q  <= (x_in == '0) && (y_in == '0);
                  // With a zero operand the result is the other one (or zero).
                  if (x_in == '0 || y_in == '0) begin
                     gcd_q <= x_in | y_in;
                  end
               end
            end
            StCmp: begin
               if (!abort && x_q == y_q) begin
                  gcd_q <= x_q;
               end
            end
            StSubX: begin
               if (!abort) begin
                  x_q    <= x_q - y_q;
                  iter_q <= iter_inc;
               end
            end
            StSubY: begin
               if (!abort) begin
                  y_q    <= y_q - x_q;
                  iter_q <= iter_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign gcd_out  = gcd_q;
   assign iter_cnt = iter_q;
   assign err      = err_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine: stimulus pushes expected results, a monitor
// pops and compares each time done rises.
module tb_gcd_engine;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       ack = 1'b0;
   logic [7:0] x_in = '0;
   logic [7:0] y_in = '0;

   logic       ready, done, err;
   logic [7:0] gcd_out, iter_cnt;
   logic       ready2, done2, err2;
   logic [7:0] gcd2;
   logic [3:0] iter2;

   typedef struct {
      logic [7:0] g;
      logic [7:0] it;
      logic       e;
      int         lat;
      int         acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   edge_cnt = 0;
   logic done_seen = 1'b0;

   gcd_engine #(.WIDTH(8), .ITER_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in), .abort(abort),
      .ack(ack), .ready(ready), .done(done), .gcd_out(gcd_out), .iter_cnt(iter_cnt),
      .err(err)
   );

   gcd_engine #(.WIDTH(8), .ITER_W(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in), .abort(abort),
      .ack(ack), .ready(ready2), .done(done2), .gcd_out(gcd2), .iter_cnt(iter2),
      .err(err2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (done && !done_seen) begin
         exp_t e;
         done_seen = 1'b1;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no result (t=%0t)", $time);
         end else begin
            e = sb.pop_front();
            check("gcd_out", gcd_out, e.g);
            check("iter_cnt", iter_cnt, e.it);
            check("err", err, e.e);
            check("latency", edge_cnt - e.acc + 1, e.lat);
         end
      end
      if (!done) done_seen = 1'b0;
   end

   task automatic do_start(input logic [7:0] x, input logic [7:0] y, input bit push,
                           input logic [7:0] g, input logic [7:0] it, input logic e,
                           input int lat);
      exp_t ent;
      @(negedge clk);
      x_in  = x;
      y_in  = y;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (push) begin
         ent.g = g; ent.it = it; ent.e = e; ent.lat = lat; ent.acc = edge_cnt;
         sb.push_back(ent);
      end
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (!done && n < bound) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", bound);
      end
   endtask

   task automatic do_ack();
      @(negedge clk);
      ack = 1'b1;
      @(posedge clk);
      #1 ack = 1'b0;
      check("ack_ready", ready, 1);
      check("ack_done", done, 0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1);
      check("rst_done", done, 0);
      check("rst_gcd", gcd_out, 0);
      check("rst_iter", iter_cnt, 0);
      check("rst_err", err, 0);
      rst = 1'b1;

      do_start(8'd12, 8'd8, 1, 8'd4, 8'd2, 1'b0, 6);
      wait_done(20);
      do_ack();

      do_start(8'd0, 8'd0, 1, 8'd0, 8'd0, 1'b1, 1);
      wait_done(5);
      do_ack();

      do_start(8'd0, 8'd9, 1, 8'd9, 8'd0, 1'b0, 1);
      wait_done(5);
      do_ack();

      do_start(8'd255, 8'd1, 1, 8'd1, 8'd254, 1'b0, 510);
      wait_done(600);
      check("sat_done", done2, 1);
      check("sat_iter", iter2, 15);
      check("sat_gcd", gcd2, 1);
      check("sat_err", err2, 0);
      check("sat_ready", ready2, 0);
      do_ack();

      // Abort on the fourth edge counting the accept edge, while in CMP.
      do_start(8'd21, 8'd14, 0, 8'd0, 8'd0, 1'b0, 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check("abort_ready", ready, 1);
      check("abort_done", done, 0);
      check("abort_gcd", gcd_out, 1);
      check("abort_err", err, 0);
      check("abort_iter", iter_cnt, 1);
      repeat (3) @(negedge clk);
      check("abort_idle", ready, 1);

      do_start(8'd7, 8'd7, 1, 8'd7, 8'd0, 1'b0, 2);
      wait_done(10);
      x_in = 8'd3;
      y_in = 8'd6;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         start = ~start;
         check("hold_done", done, 1);
         check("hold_gcd", gcd_out, 7);
         check("hold_iter", iter_cnt, 0);
      end
      @(negedge clk);
      ack   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      ack   = 1'b0;
      start = 1'b0;
      check("ackstart_ready", ready, 1);
      check("ackstart_done", done, 0);
      @(negedge clk);
      check("ackstart_ignored", ready, 1);

      // Reset while in SUB_Y.
      do_start(8'd8, 8'd12, 0, 8'd0, 8'd0, 1'b0, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("midrst_ready", ready, 1);
      check("midrst_done", done, 0);
      check("midrst_gcd", gcd_out, 0);
      check("midrst_iter", iter_cnt, 0);
      check("midrst_err", err, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_idle", ready, 1);

      do_start(8'd6, 8'd9, 1, 8'd3, 8'd2, 1'b0, 6);
      wait_done(20);
      do_ack();

      repeat (3) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gcd_engine.md
GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter ITER_W, default WIDTH, iteration-counter width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-005 SHALL have port start  input  1  request to compute; accepted only when ready=1.
REQ-006 SHALL have port x_in  input  WIDTH  operand X, sampled on the accept edge.
REQ-007 SHALL have port y_in  input  WIDTH  operand Y, sampled on the accept edge.
REQ-008 SHALL have port abort  input  1  cancels a computation in progress.
REQ-009 SHALL have port ack  input  1  consumer acknowledges the result.
REQ-010 SHALL have port ready  output  1  engine idle, able to accept start.
REQ-011 SHALL have port done  output  1  result valid; held until ack.
REQ-012 SHALL have port gcd_out  output  WIDTH  result.
REQ-013 SHALL have port iter_cnt  output  ITER_W  number of subtract steps for the last/current operation.
REQ-014 SHALL have port err  output  1  both operands were zero; qualified by done.

Function
REQ-015 SHALL implement FSM states IDLE, CMP, SUB_X, SUB_Y, DONE, with registered state and X, Y working registers of WIDTH bits.
REQ-016 IDLE: ready=1; start=1 on an edge = accept: X<=x_in, Y<=y_in, iter_cnt<=0, err<=0.
REQ-017 On accept with x_in=0 and y_in!=0: next state DONE, gcd_out<=y_in; with y_in=0 and x_in!=0: DONE, gcd_out<=x_in.
REQ-018 On accept with x_in=0 and y_in=0: next state DONE, gcd_out<=0, err<=1.
REQ-019 On accept with both operands nonzero: next state CMP.
REQ-020 CMP: X>Y -> SUB_X; X<Y -> SUB_Y; X==Y -> DONE with gcd_out<=X.
REQ-021 SUB_X: X<=X-Y, next CMP; SUB_Y: Y<=Y-X, next CMP; each SHALL increment iter_cnt by 1, saturating at all-ones (no wrap).
REQ-022 Subtraction SHALL be unsigned WIDTH-bit; subtrahend is never larger than minuend by construction, so no borrow occurs.
REQ-023 Latency: nonzero operands -> done high after 2*iter_cnt+2 rising edges counting the accept edge; zero operand -> 1 edge.
REQ-024 DONE: done=1, ready=0; gcd_out, iter_cnt, err stable; ack=1 on an edge -> IDLE, done deasserts next cycle.
REQ-025 start SHALL be ignored in every state other than IDLE (including DONE, including same edge as ack).
REQ-026 abort=1 on an edge in CMP, SUB_X or SUB_Y -> IDLE; done not asserted; gcd_out and err retain prior values; iter_cnt holds partial count.
REQ-027 abort SHALL be ignored in IDLE and DONE; abort has priority over FSM progress in CMP/SUB states.
REQ-028 ready SHALL be combinational from state (1 only in IDLE); done likewise (1 only in DONE).
REQ-029 gcd_out SHALL update only on entry to DONE and hold its value otherwise.

Reset
REQ-030 rst=0 on an edge SHALL force IDLE from any state, mid-computation included, overriding start, abort and ack.
REQ-031 Reset values: ready=1, done=0, gcd_out=0, iter_cnt=0, err=0, X=0, Y=0.

Verification
REQ-032 x_in=12, y_in=8, start pulse -> states CMP,SUB_X,CMP,SUB_Y,CMP,DONE; done after 6 edges; gcd_out=4, iter_cnt=2, err=0.
REQ-033 x_in=0, y_in=0 -> done after 1 edge, gcd_out=0, err=1; x_in=0, y_in=9 -> gcd_out=9, err=0.
REQ-034 WIDTH=8, x_in=255, y_in=1 -> 254 SUB_X steps, gcd_out=1, iter_cnt=254; ITER_W=4 same operands -> iter_cnt saturates at 15.
REQ-035 Start 21,14; abort asserted 3 edges after accept -> IDLE next edge, done never rises, gcd_out unchanged; new start 7,7 -> gcd_out=7, iter_cnt=0.
REQ-036 In DONE hold ack=0 for 5 cycles with start toggling -> done stays 1, result stable; ack=1 -> IDLE next edge, start same edge ignored.
REQ-037 rst=0 during SUB_Y -> next edge all outputs at REQ-031 values; operation fully abandoned.
